// File: rtl/ram_sp_ctrl.sv
// Single-port RAM behind a valid/ready request/response handshake.
// A reset or init_req fills the RAM with an ascending pattern before requests are served.
module ram_sp_ctrl #(
    parameter int          AW          = 4,
    parameter int          DW          = 8,
    parameter int unsigned INIT_BASE   = 8'h41,
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_req,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy
);

    localparam int            DEPTH   = 2 ** AW;
    localparam logic [0:0]    ST_INIT = 1'b0;
    localparam logic [0:0]    ST_IDLE = 1'b1;
    localparam logic [AW-1:0] K_LAST  = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    logic [0:0]    state_reg, state_next;
    logic [AW-1:0] k_reg, k_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0] rsp_rdata_reg, rsp_rdata_next;

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] init_word;

    assign busy      = (state_reg == ST_INIT);
    assign req_ready = (state_reg == ST_IDLE) && !init_req && (!rsp_valid_reg || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

    // Pattern word wraps naturally modulo 2**DW through the truncating cast.
    assign init_word = DW'(INIT_BASE + 32'(k_reg));

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            ST_INIT: begin
                // init_req is ignored here; the counter parks at K_LAST instead of wrapping.
                if (k_reg == K_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            default: begin
                if (init_req) begin
                    state_next = ST_INIT;
                    k_next     = '0;
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        if (accept) begin
            rsp_valid_next = 1'b1;
            if (WRITE_FIRST && req_we) begin
                rsp_rdata_next = req_wdata;
            end else begin
                rsp_rdata_next = mem[req_addr];
            end
        end else if (rsp_ready) begin
            rsp_valid_next = 1'b0;
        end
    end

    // The fill and request writes share one write port; they never overlap.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (busy) begin
            mem_we    = rst_n;
            mem_addr  = k_reg;
            mem_wdata = init_word;
        end else if (accept && req_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            k_reg         <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Directed bench for ram_sp_ctrl: read-first and write-first instances share one stimulus.
`timescale 1ns/1ps
module tb_ram_sp_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       init_req  = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we    = 1'b0;
    logic [3:0] req_addr  = 4'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_ready = 1'b0;

    logic       req_ready, rsp_valid, busy;
    logic [7:0] rsp_rdata;
    logic       req_ready_wf, rsp_valid_wf, busy_wf;
    logic [7:0] rsp_rdata_wf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_sp_ctrl #(.AW(4), .DW(8), .INIT_BASE('h41), .WRITE_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    ram_sp_ctrl #(.AW(4), .DW(8), .INIT_BASE('h41), .WRITE_FIRST(1'b1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .req_valid(req_valid), .req_ready(req_ready_wf), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_wf), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_wf),
        .busy(busy_wf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy falls; optionally re-pulses init_req mid-fill.
    task automatic wait_init(input string tag, input int reinit_at);
        int cnt = 0;
        do begin
            if (busy) check({tag, "_rdy"}, 32'(req_ready), 0);
            step();
            cnt++;
            init_req = (cnt == reinit_at);
            if (!busy) req_valid = 1'b0;
        end while (busy && cnt < 40);
        init_req = 1'b0;
        check({tag, "_len"}, cnt, 16);
        check({tag, "_wf"}, 32'(busy_wf), 0);
        $display("init fill %s: %0d cycles", tag, cnt);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [3:0] addr,
                          input logic [7:0] wd, input int exp, input int exp_wf);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        check({tag, "_vld"}, 32'(rsp_valid), 1);
        check({tag, "_dat"}, 32'(rsp_rdata), exp);
        check({tag, "_dat_wf"}, 32'(rsp_rdata_wf), exp_wf);
        $display("%s addr %0d wdata 0x%02h -> rsp 0x%02h / wf 0x%02h",
                 we ? "wr" : "rd", addr, wd, rsp_rdata, rsp_rdata_wf);
        step();
    endtask

    logic [3:0] b2b_addr [4];
    int         b2b_exp  [4];

    initial begin
        b2b_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        b2b_exp  = '{'h4F, 'h50, 'h41, 'h42};

        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", 32'(busy), 1);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_vld", 32'(rsp_valid), 0);
        check("rst_dat", 32'(rsp_rdata), 0);
        @(negedge clk) rst_n = 1'b1;
        wait_init("por", -1);

        for (int i = 0; i < 16; i++)
            do_req($sformatf("sweep%0d", i), 1'b0, 4'(i), 8'h00, 'h41 + i, 'h41 + i);

        // Back-to-back reads across the address wrap.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = b2b_addr[i];
            #1;
            check($sformatf("b2b%0d_rdy", i), 32'(req_ready), 1);
            step();
            check($sformatf("b2b%0d_vld", i), 32'(rsp_valid), 1);
            check($sformatf("b2b%0d_dat", i), 32'(rsp_rdata), b2b_exp[i]);
            $display("b2b rd addr %0d -> rsp 0x%02h", b2b_addr[i], rsp_rdata);
        end
        req_valid = 1'b0;
        step();
        check("b2b_drop_vld", 32'(rsp_valid), 0);
        check("b2b_drop_dat", 32'(rsp_rdata), 'h42);

        do_req("wr1", 1'b1, 4'd1, 8'h5A, 'h42, 'h5A);
        do_req("rd1", 1'b0, 4'd1, 8'h00, 'h5A, 'h5A);

        // Backpressure: a write held off for 3 cycles must not touch memory early.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd2;
        rsp_ready = 1'b1;
        step();
        check("bp_first_dat", 32'(rsp_rdata), 'h43);
        rsp_ready = 1'b0;
        req_we    = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 8'hAA;
        #1;
        check("bp_rdy0", 32'(req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp%0d_vld", i), 32'(rsp_valid), 1);
            check($sformatf("bp%0d_dat", i), 32'(rsp_rdata), 'h43);
            check($sformatf("bp%0d_rdy", i), 32'(req_ready), 0);
            $display("stall cycle %0d: rsp 0x%02h held", i, rsp_rdata);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_resume_rdy", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("bp_wr_vld", 32'(rsp_valid), 1);
        check("bp_wr_dat", 32'(rsp_rdata), 'h44);
        check("bp_wr_dat_wf", 32'(rsp_rdata_wf), 'hAA);
        step();
        do_req("bp_rd3", 1'b0, 4'd3, 8'h00, 'hAA, 'hAA);

        // init_req wins over a simultaneous write; writes during the fill are dropped.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 8'hEE;
        rsp_ready = 1'b1;
        init_req  = 1'b1;
        #1;
        check("ireq_rdy", 32'(req_ready), 0);
        step();
        init_req = 1'b0;
        check("ireq_busy", 32'(busy), 1);
        check("ireq_vld", 32'(rsp_valid), 0);
        wait_init("reinit", 3);
        do_req("reinit_rd1", 1'b0, 4'd1, 8'h00, 'h42, 'h42);
        do_req("reinit_rd5", 1'b0, 4'd5, 8'h00, 'h46, 'h46);

        // A pending response survives init_req until consumed.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd7;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        check("pend_dat", 32'(rsp_rdata), 'h48);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("pend_busy", 32'(busy), 1);
        check("pend_vld", 32'(rsp_valid), 1);
        step();
        step();
        check("pend_vld2", 32'(rsp_valid), 1);
        check("pend_dat2", 32'(rsp_rdata), 'h48);
        rsp_ready = 1'b1;
        step();
        check("pend_drop", 32'(rsp_valid), 0);
        for (int i = 0; i < 40 && busy; i++) step();
        check("pend_done", 32'(busy), 0);

        // Reset at k=7 of a fill.
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        check("rk7_busy", 32'(busy), 1);
        check("rk7_rdy", 32'(req_ready), 0);
        check("rk7_vld", 32'(rsp_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        wait_init("rst_k7", -1);

        // Reset with a response outstanding.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd9;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        check("rv_vld", 32'(rsp_valid), 1);
        check("rv_dat", 32'(rsp_rdata), 'h4A);
        #2 rst_n = 1'b0;
        #1;
        check("rv_rst_vld", 32'(rsp_valid), 0);
        check("rv_rst_dat", 32'(rsp_rdata), 0);
        check("rv_rst_busy", 32'(busy), 1);
        @(negedge clk) rst_n = 1'b1;
        wait_init("rst_rsp", -1);
        do_req("post_rd1", 1'b0, 4'd1, 8'h00, 'h42, 'h42);
        do_req("post_rd9", 1'b0, 4'd9, 8'h00, 'h4A, 'h4A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
